pipe_ctrl: RTL and testbench

Central pipeline-control sequencer for the 5-stage core. It consumes the ID-stage stall request from the hazard unit, the EX-stage branch redirect, the data-memory wait and the ID-stage halt request, and drives the per-stage register enables, the IF/ID flush and the ID/EX bubble mux. It sequences the halt drain and keeps stall and flush performance counters. It also runs a stall watchdog that flags pipeline deadlock.

---
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline-control sequencer: stage enables, IF/ID flush, ID/EX bubble,
// halt drain sequencing, stall/flush performance counters and stall watchdog.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_STALL    = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic             err_deadlock,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam logic [7:0] STALL_MAX  = 8'(MAX_STALL);

    state_t           state_reg, state_next;
    logic [3:0]       drain_cnt_reg, drain_cnt_next;
    logic [7:0]       stall_run_reg, stall_run_next;
    logic             err_reg;
    logic [CNT_W-1:0] stall_count_reg, flush_count_reg;
    logic             stall_inc, flush_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            drain_cnt_reg   <= '0;
            stall_run_reg   <= '0;
            err_reg         <= 1'b0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            stall_run_reg <= stall_run_next;
            if (stall_run_next == STALL_MAX)
                err_reg <= 1'b1;
            stall_count_reg <= stall_count_reg + {{(CNT_W-1){1'b0}}, stall_inc};
            flush_count_reg <= flush_count_reg + {{(CNT_W-1){1'b0}}, flush_inc};
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        stall_run_next = stall_run_reg;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        pc_en          = 1'b0;
        if_id_en       = 1'b0;
        id_ex_en       = 1'b0;
        ex_mem_en      = 1'b0;
        mem_wb_en      = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;

        case (state_reg)
            RUN: begin
                if (mem_busy) begin
                    // full freeze; watchdog run length is held, not cleared
                end else if (branch_taken) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    if_id_flush    = 1'b1;
                    id_ex_bubble   = 1'b1;
                    flush_inc      = 1'b1;
                    stall_run_next = '0;
                end else if (halt_req) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b01111;
                    if_id_flush    = 1'b1;
                    id_ex_bubble   = 1'b1;
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_INIT;
                    stall_run_next = '0;
                end else if (stall_req) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00111;
                    id_ex_bubble   = 1'b1;
                    stall_inc      = 1'b1;
                    stall_run_next = (stall_run_reg == STALL_MAX) ? STALL_MAX
                                                                  : stall_run_reg + 8'd1;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    stall_run_next = '0;
                end
            end
            DRAIN: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (!mem_busy) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b01111;
                    drain_cnt_next = drain_cnt_reg - 4'd1;
                    if (drain_cnt_reg == 4'd1)
                        state_next = HALTED;
                end
            end
            HALTED: begin
            end
            default: state_next = RUN;
        endcase

        // While in reset the pipeline is held with NOPs injected.
        if (!rst_n) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign halted       = (state_reg == HALTED);
    assign err_deadlock = err_reg;
    assign stall_count  = stall_count_reg;
    assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, stall, priority, watchdog, counter wrap
// and halt drain, with hand-computed expectations (CNT_W=4 to exercise wrap).
module tb_pipe_ctrl;

    localparam int CW = 4;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble}
    localparam logic [6:0] RST_V   = 7'b00000_11;
    localparam logic [6:0] ALL_V   = 7'b11111_00;
    localparam logic [6:0] ZERO_V  = 7'b00000_00;
    localparam logic [6:0] STALL_V = 7'b00111_01;
    localparam logic [6:0] BR_V    = 7'b11111_11;
    localparam logic [6:0] HALT_V  = 7'b01111_11;
    localparam logic [6:0] DBUSY_V = 7'b00000_11;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic stall_req = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0, halt_req = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_bubble, halted, err_deadlock;
    logic [CW-1:0] stall_count, flush_count;
    logic [6:0] outs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble};

    pipe_ctrl #(.DRAIN_CYCLES(3), .MAX_STALL(8), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .stall_req(stall_req), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .halted(halted), .err_deadlock(err_deadlock),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs for one cycle, check combinational outputs mid-cycle,
    // then return 1 time unit after the closing edge.
    task automatic step(input string tag, input logic s, input logic b,
                        input logic m, input logic h, input logic [6:0] exp);
        stall_req = s; branch_taken = b; mem_busy = m; halt_req = h;
        @(negedge clk);
        check(tag, 32'(outs), 32'(exp));
        @(posedge clk); #1;
        stall_req = 0; branch_taken = 0; mem_busy = 0; halt_req = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_halted_async", 32'(halted), 0);
        check("rst_err", 32'(err_deadlock), 0);
        check("rst_outs", 32'(outs), 32'(RST_V));
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_outs", 32'(outs), 32'(RST_V));
        check("rst_stall_cnt", 32'(stall_count), 0);
        check("rst_flush_cnt", 32'(flush_count), 0);
        rst_n = 1'b1;
        step("post_rst", 0, 0, 0, 0, ALL_V);
    endtask

    initial begin
        #2;
        do_reset();

        // Hazard stall
        step("stall1", 1, 0, 0, 0, STALL_V);
        step("stall2", 1, 0, 0, 0, STALL_V);
        check("stall_cnt2", 32'(stall_count), 2);
        check("err_after2", 32'(err_deadlock), 0);
        step("idle1", 0, 0, 0, 0, ALL_V);

        // Priority
        step("br_over_stall", 1, 1, 0, 0, BR_V);
        check("flush_cnt1", 32'(flush_count), 1);
        check("stall_cnt_keep", 32'(stall_count), 2);
        step("busy_over_all", 1, 1, 1, 1, ZERO_V);
        check("flush_cnt_busy", 32'(flush_count), 1);
        check("stall_cnt_busy", 32'(stall_count), 2);
        step("no_drain_after_busy", 0, 0, 0, 0, ALL_V);

        // Watchdog: 7 stalls no error, 8th sets it
        for (int i = 0; i < 7; i++) step("wd_stall", 1, 0, 0, 0, STALL_V);
        check("wd_err_7", 32'(err_deadlock), 0);
        step("wd_stall8", 1, 0, 0, 0, STALL_V);
        check("wd_err_8", 32'(err_deadlock), 1);
        step("wd_idle", 0, 0, 0, 0, ALL_V);
        check("wd_err_sticky", 32'(err_deadlock), 1);
        check("stall_cnt10", 32'(stall_count), 10);
        step("wd_stall_after_err", 1, 0, 0, 0, STALL_V);

        // mem_busy holds the stall run: 3+busy+3 = 6, two more reach 8
        do_reset();
        for (int i = 0; i < 3; i++) step("hold_a", 1, 0, 0, 0, STALL_V);
        step("hold_busy", 1, 0, 1, 0, ZERO_V);
        for (int i = 0; i < 3; i++) step("hold_b", 1, 0, 0, 0, STALL_V);
        check("hold_err_6", 32'(err_deadlock), 0);
        for (int i = 0; i < 2; i++) step("hold_c", 1, 0, 0, 0, STALL_V);
        check("hold_err_8", 32'(err_deadlock), 1);
        check("hold_stall_cnt", 32'(stall_count), 8);

        // Idle clears the stall run: 3+idle+5 never reaches 8
        do_reset();
        for (int i = 0; i < 3; i++) step("clr_a", 1, 0, 0, 0, STALL_V);
        step("clr_idle", 0, 0, 0, 0, ALL_V);
        for (int i = 0; i < 5; i++) step("clr_b", 1, 0, 0, 0, STALL_V);
        check("clr_err", 32'(err_deadlock), 0);

        // Counter wrap with 4-bit counters
        do_reset();
        for (int i = 0; i < 17; i++) step("wrap_stall", 1, 0, 0, 0, STALL_V);
        check("wrap_stall_cnt", 32'(stall_count), 1);

        // Halt drain, no mem_busy; requests during drain are ignored
        do_reset();
        step("halt_acc", 1, 0, 0, 1, HALT_V);
        check("halt_acc_halted", 32'(halted), 0);
        step("drain1", 1, 1, 0, 0, HALT_V);
        step("drain2", 0, 0, 0, 1, HALT_V);
        check("drain2_halted", 32'(halted), 0);
        step("drain3", 0, 0, 0, 0, HALT_V);
        check("halted_set", 32'(halted), 1);
        step("halted_outs", 1, 1, 0, 1, ZERO_V);
        check("halt_flush_cnt", 32'(flush_count), 0);
        check("halt_stall_cnt", 32'(stall_count), 0);
        check("halted_stays", 32'(halted), 1);

        // Halt drain with one mem_busy cycle
        do_reset();
        step("hb_acc", 0, 0, 0, 1, HALT_V);
        step("hb_drain1", 0, 0, 0, 0, HALT_V);
        step("hb_busy", 0, 0, 1, 0, DBUSY_V);
        step("hb_drain2", 0, 0, 0, 0, HALT_V);
        check("hb_not_yet", 32'(halted), 0);
        step("hb_drain3", 0, 0, 0, 0, HALT_V);
        check("hb_halted", 32'(halted), 1);
        step("hb_halted_outs", 0, 0, 0, 0, ZERO_V);

        // Asynchronous reset out of HALTED
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
